// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, optional wait states,
// byte/half/word access with lane merge on stores and sign/zero extension on loads.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_LOCS    = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [1:0]            o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // req_ready is high only in IDLE; resp_valid holds with stable data until resp_ready.

    localparam int                    IDX_W     = (NUM_LOCS > 1) ? $clog2(NUM_LOCS) : 1;
    localparam bit                    ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]            CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-3:0] LOCS_W    = (ADDR_WIDTH-2)'(NUM_LOCS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [DATA_WIDTH-1:0] r_mem [NUM_LOCS];
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_exec;
    logic                  w_ex_write;
    logic [ADDR_WIDTH-1:0] w_ex_addr;
    logic [DATA_WIDTH-1:0] w_ex_wdata;
    logic [1:0]            w_ex_size;
    logic                  w_ex_unsigned;
    logic [1:0]            w_lane;
    logic [ADDR_WIDTH-3:0] w_word_idx;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_error;
    logic [DATA_WIDTH-1:0] w_old;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_lane_data;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;

    assign w_accept = (r_state == S_IDLE) && req_valid && r_req_ready;
    assign w_exec   = (w_accept && ZERO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

    // With no wait states the access executes on the accept edge, straight from the inputs.
    assign w_ex_write    = (r_state == S_IDLE) ? req_write    : r_write;
    assign w_ex_addr     = (r_state == S_IDLE) ? req_addr     : r_addr;
    assign w_ex_wdata    = (r_state == S_IDLE) ? req_wdata    : r_wdata;
    assign w_ex_size     = (r_state == S_IDLE) ? req_size     : r_size;
    assign w_ex_unsigned = (r_state == S_IDLE) ? req_unsigned : r_unsigned;

    assign w_lane     = w_ex_addr[1:0];
    assign w_word_idx = w_ex_addr[ADDR_WIDTH-1:2];
    assign w_idx      = w_word_idx[IDX_W-1:0];
    assign w_old      = r_mem[w_idx];

    assign w_error = (w_ex_size == 2'b11)
                  || ((w_ex_size == 2'b01) && w_lane[0])
                  || ((w_ex_size == 2'b10) && (w_lane != 2'b00))
                  || (w_word_idx >= LOCS_W);

    always_comb begin
        w_be        = 4'b0000;
        w_lane_data = w_ex_wdata;
        case (w_ex_size)
            2'b00: begin
                w_be        = 4'b0001 << w_lane;
                w_lane_data = {4{w_ex_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << {w_lane[1], 1'b0};
                w_lane_data = {2{w_ex_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        w_merged = w_old;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w_merged[8*i +: 8] = w_lane_data[8*i +: 8];
        end
    end

    always_comb begin
        w_byte = w_old[{w_lane, 3'b000} +: 8];
        w_half = w_old[{w_lane[1], 4'b0000} +: 16];
        case (w_ex_size)
            2'b00:   w_load = w_ex_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = w_ex_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_old;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_error      <= 1'b0;
            for (int i = 0; i < NUM_LOCS; i++) r_mem[i] <= '0;
        end else begin
            if (w_exec) begin
                r_error      <= w_error;
                r_rdata      <= (w_error || w_ex_write) ? '0 : w_load;
                r_resp_valid <= 1'b1;
                if (w_ex_write && !w_error) r_mem[w_idx] <= w_merged;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_req_ready <= 1'b0;
                        if (ZERO_WAIT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_rdata      <= '0;
                        r_error      <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_rdata;
    assign resp_error  = r_error;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has one wait state, instance 1 has none.
// A byte-array model predicts each response; one negedge process checks the outputs.
module tb_dmem_responder;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid    [NI];
    logic        req_ready    [NI];
    logic        req_write    [NI];
    logic [31:0] req_addr     [NI];
    logic [31:0] req_wdata    [NI];
    logic [1:0]  req_size     [NI];
    logic        req_unsigned [NI];
    logic        resp_valid   [NI];
    logic        resp_ready   [NI];
    logic [31:0] resp_rdata   [NI];
    logic        resp_error   [NI];
    logic [1:0]  dbg_state    [NI];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [33:0] exp_q[$];
    logic [7:0]  mm [NI][256];
    int          acc_cyc  [NI];
    logic [32:0] last_rsp [NI];
    logic        prev_valid [NI];
    logic        prev_hs    [NI];
    logic [31:0] prev_rdata [NI];
    logic        prev_err   [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .o_dbg_state(dbg_state[0])
    );

    dmem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .o_dbg_state(dbg_state[1])
    );

    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-addressed reference: returns {error, rdata} and applies stores to mm.
    function automatic logic [32:0] model_access(input int g, input logic wr, input logic [31:0] addr,
                                                 input logic [31:0] wdata, input logic [1:0] size,
                                                 input logic uns);
        int          nb;
        logic [31:0] v;
        bit          err;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)
              || ((addr >> 2) >= 64);
        if (err) return {1'b1, 32'h0};
        if (wr) begin
            for (int b = 0; b < nb; b++) mm[g][int'(addr[7:0]) + b] = wdata[8*b +: 8];
            return 33'h0;
        end
        v = 32'h0;
        for (int b = 0; b < nb; b++) v[8*b +: 8] = mm[g][int'(addr[7:0]) + b];
        if (nb < 4 && !uns && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
        return {1'b0, v};
    endfunction

    task automatic clear_model();
        for (int g = 0; g < NI; g++)
            for (int a = 0; a < 256; a++) mm[g][a] = 8'h00;
        exp_q.delete();
    endtask

    // hold < 0: resp_ready is left as is (tied high); otherwise hold it low that many cycles.
    task automatic do_req(input int g, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input int hold);
        int budget;
        budget = 0;
        while (!req_ready[g] && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!req_ready[g]) begin
            chk("req_ready_timeout", {63'b0, req_ready[g]}, 64'd1);
            return;
        end
        req_valid[g]    = 1'b1;
        req_write[g]    = wr;
        req_addr[g]     = addr;
        req_wdata[g]    = wdata;
        req_size[g]     = size;
        req_unsigned[g] = uns;
        exp_q.push_back({1'(g), model_access(g, wr, addr, wdata, size, uns)});
        acc_cyc[g] = cyc + 1;
        @(posedge clk); #1;
        req_valid[g]    = 1'b0;
        req_write[g]    = 1'($urandom_range(0, 1));
        req_addr[g]     = $urandom;
        req_wdata[g]    = $urandom;
        req_size[g]     = 2'($urandom_range(0, 3));
        req_unsigned[g] = 1'($urandom_range(0, 1));
        if (hold >= 0) begin
            budget = 0;
            while (!resp_valid[g] && budget < 50) begin
                @(posedge clk); #1;
                budget++;
            end
            if (!resp_valid[g]) begin
                chk("resp_valid_timeout", {63'b0, resp_valid[g]}, 64'd1);
                return;
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            resp_ready[g] = 1'b1;
            @(posedge clk); #1;
            resp_ready[g] = 1'b0;
        end
    endtask

    task automatic rand_req(input int g, input int hold);
        int          r;
        logic [1:0]  size;
        logic [31:0] addr;
        r    = $urandom_range(0, 9);
        size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        addr = 32'($urandom_range(0, 32'h10F));
        if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~((32'h1 << size) - 32'h1);
        do_req(g, 1'($urandom_range(0, 1)), addr, $urandom, size, 1'($urandom_range(0, 1)), hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk({tag, "_req_ready"},  {63'b0, req_ready[g]},  64'd1);
            chk({tag, "_resp_valid"}, {63'b0, resp_valid[g]}, 64'd0);
            chk({tag, "_resp_rdata"}, {32'b0, resp_rdata[g]}, 64'd0);
            chk({tag, "_resp_error"}, {63'b0, resp_error[g]}, 64'd0);
        end
    endtask

    // Compare process: response contents, stability while stalled, latency, ready behaviour.
    initial forever begin
        logic [33:0] e;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            if (!rstn) begin
                prev_valid[g] = 1'b0;
                prev_hs[g]    = 1'b0;
            end else begin
                if (prev_hs[g]) begin
                    chk("resp_valid_after_hs", {63'b0, resp_valid[g]}, 64'd0);
                    chk("req_ready_after_hs",  {63'b0, req_ready[g]},  64'd1);
                end
                if (resp_valid[g]) begin
                    chk("req_ready_while_resp", {63'b0, req_ready[g]}, 64'd0);
                    if (!prev_valid[g]) begin
                        chk("latency", 64'(cyc - acc_cyc[g] + 1), 64'(wait_of(g) + 1));
                    end else begin
                        chk("stall_rdata", {32'b0, resp_rdata[g]}, {32'b0, prev_rdata[g]});
                        chk("stall_error", {63'b0, resp_error[g]}, {63'b0, prev_err[g]});
                    end
                    if (resp_ready[g]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_resp", 64'(exp_q.size()), 64'd1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("resp_instance", 64'(g), {63'b0, e[33]});
                            chk("resp_error", {63'b0, resp_error[g]}, {63'b0, e[32]});
                            chk("resp_rdata", {32'b0, resp_rdata[g]}, {32'b0, e[31:0]});
                            last_rsp[g] = {resp_error[g], resp_rdata[g]};
                        end
                    end
                end
                prev_valid[g] = resp_valid[g];
                prev_hs[g]    = resp_valid[g] && resp_ready[g];
                prev_rdata[g] = resp_rdata[g];
                prev_err[g]   = resp_error[g];
            end
        end
    end

    initial begin
        int a0;
        int budget;
        rstn = 1'b0;
        for (int g = 0; g < NI; g++) begin
            req_valid[g]    = 1'b0;
            req_write[g]    = 1'b0;
            req_addr[g]     = 32'h0;
            req_wdata[g]    = 32'h0;
            req_size[g]     = 2'd0;
            req_unsigned[g] = 1'b0;
            acc_cyc[g]      = 0;
            last_rsp[g]     = 33'h0;
        end
        resp_ready[0] = 1'b0;
        resp_ready[1] = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // One wait state: directed word/byte/half traffic.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0);
        do_req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
        chk("lit_word_load", 64'(last_rsp[0]), 64'h0_DEADBEEF);
        do_req(0, 1'b1, 32'h11, 32'hAAAAAA7F, 2'd0, 1'b0, 0);
        do_req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 0);
        chk("lit_merged_word", 64'(last_rsp[0]), 64'h0_DEAD7FEF);
        do_req(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0);
        chk("lit_byte_signed", 64'(last_rsp[0]), 64'h0_FFFFFFDE);
        do_req(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0);
        chk("lit_byte_unsigned", 64'(last_rsp[0]), 64'h0_000000DE);
        do_req(0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 0);
        chk("lit_half_signed", 64'(last_rsp[0]), 64'h0_FFFFDEAD);
        do_req(0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 0);
        chk("lit_half_unsigned", 64'(last_rsp[0]), 64'h0_0000DEAD);

        // Rejected accesses.
        do_req(0, 1'b0, 32'h21, 32'h0, 2'd1, 1'b0, 0);
        chk("lit_err_half_misalign", 64'(last_rsp[0]), 64'h1_00000000);
        do_req(0, 1'b0, 32'h22, 32'h0, 2'd2, 1'b0, 0);
        chk("lit_err_word_misalign", 64'(last_rsp[0]), 64'h1_00000000);
        do_req(0, 1'b0, 32'h20, 32'h0, 2'd3, 1'b0, 0);
        chk("lit_err_size", 64'(last_rsp[0]), 64'h1_00000000);
        do_req(0, 1'b1, 32'h100, 32'h11223344, 2'd2, 1'b0, 0);
        chk("lit_err_range", 64'(last_rsp[0]), 64'h1_00000000);
        do_req(0, 1'b1, 32'h21, 32'hFFFFFFFF, 2'd1, 1'b0, 0);
        do_req(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0);
        chk("lit_mem_untouched", 64'(last_rsp[0]), 64'h0_00000000);

        // Stalled response.
        do_req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5);
        chk("lit_after_stall", 64'(last_rsp[0]), 64'h0_DEAD7FEF);

        // Reset during WAIT aborts the store.
        while (!req_ready[0]) begin
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h8;
        req_wdata[0] = 32'h12345678; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #1 rstn = 1'b0;
        #1;
        check_reset_outputs("midwait_reset");
        clear_model();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, 0);
        chk("lit_load_after_reset", 64'(last_rsp[0]), 64'h0_00000000);

        for (int i = 0; i < 80; i++) rand_req(0, $urandom_range(0, 2));

        // No wait states, resp_ready tied high: one request every two cycles.
        do_req(1, 1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0, -1);
        a0 = acc_cyc[1];
        do_req(1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, -1);
        chk("throughput_directed", 64'(acc_cyc[1] - a0), 64'd2);
        @(negedge clk); #1;
        chk("lit_zero_wait_load", 64'(last_rsp[1]), 64'h0_CAFEF00D);
        for (int i = 0; i < 60; i++) begin
            a0 = acc_cyc[1];
            rand_req(1, -1);
            chk("throughput", 64'(acc_cyc[1] - a0), 64'd2);
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that sits behind the MEM pipeline stage and serves its load/store requests.
- Uses a valid/ready request channel and a valid/ready response channel, with a parameterised number of wait states.
- Handles byte, halfword and word access on a word-organised array, with byte-lane merge on stores and sign/zero extension on loads.
- Reports misaligned, out-of-range and illegal-size accesses instead of performing them.

Parameters:
ADDR_WIDTH  32  request address width in bits
DATA_WIDTH  32  data width in bits; fixed at 32 for lane logic
NUM_LOCS  64  number of 32-bit words in the array
WAIT_CYCLES  1  cycles spent in WAIT before the access executes; 0 to 15

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data; low bits are used for byte/half
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_WIDTH  load result; 0 for stores and for errors
resp_error  out  1  access rejected

Behaviour:
- Reset (asynchronous, rstn low):
  - state returns to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0.
  - the wait counter and captured request are cleared.
  - all NUM_LOCS words are cleared to 0.
  - reset arriving mid-transaction aborts it; a store not yet executed never writes.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture write, addr, wdata, size and unsigned.
  - If WAIT_CYCLES==0, execute the access on this edge and go to RESP.
  - Otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - When the counter is 0, execute the access and go to RESP; otherwise decrement.
  - Minimum latency from accept edge to resp_valid high is WAIT_CYCLES+1 edges (1 edge when WAIT_CYCLES=0).
- RESP:
  - resp_valid=1 and req_ready=0.
  - resp_rdata and resp_error are stable while resp_valid&&!resp_ready.
  - On resp_ready, return to IDLE; resp_valid drops on the next edge.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Error check (at execute time):
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index addr>>2 >= NUM_LOCS.
  - On error: resp_error=1, resp_rdata=0, memory unchanged.
- Store:
  - word index is addr>>2; byte lane is addr[1:0].
  - byte writes wdata[7:0] into lane addr[1:0];
  - half writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1};
  - word writes all four lanes.
  - Unselected lanes are preserved; resp_rdata=0.
- Load:
  - extract the byte or half from the selected lane; little-endian, lane 0 = bits 7:0.
  - extend to 32 bits: zero-extend when req_unsigned=1, sign-extend when 0.
  - word loads ignore req_unsigned.
- req_* inputs are ignored outside the IDLE accept handshake; changing them later has no effect on the captured request.
- resp_ready asserted while resp_valid=0 has no effect.

Test Plan:
- WAIT_CYCLES=1: store word 0xDEADBEEF to 0x10, then load word from 0x10 -> resp_rdata=0xDEADBEEF, resp_error=0, resp_valid rises 2 edges after each accept.
- After the above: store byte 0x7F to 0x11, then load word 0x10 -> 0xDEAD7FEF; load byte 0x13 signed -> 0xFFFFFFDE; load byte 0x13 unsigned -> 0x000000DE; load half 0x12 signed -> 0xFFFFDEAD.
- Load half at 0x21, load word at 0x22, request with size 11, and word access at 0x100 (index 64) -> resp_error=1 and resp_rdata=0 for each; memory at 0x20 still 0.
- Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_rdata and resp_error stay constant and req_ready=0; raise resp_ready -> IDLE next edge with req_ready=1.
- Start a store of 0x12345678 to 0x8, drop rstn during WAIT -> outputs return to reset values immediately; a load from 0x8 after reset returns 0.
- WAIT_CYCLES=0: back-to-back store/load with resp_ready tied 1 -> each response 1 edge after accept; one request per 2 cycles.
